// File: rtl/coherent_avg_pkg.sv
// Shared types and helpers for the multi-channel coherent averager.
package coherent_avg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int M_MIN = 2;

  // Arithmetic right shift followed by clamping to a signed dw-bit range.
  function automatic logic signed [63:0] shift_sat(input logic signed [63:0] acc,
                                                   input logic [4:0]         sh,
                                                   input int                 dw);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = acc >>> sh;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (s > hi) return hi;
    else if (s < lo) return lo;
    else return s;
  endfunction

endpackage

// File: rtl/coherent_avg_ram.sv
// Simple dual-port synchronous RAM, one write port and one read port, read latency 1.
module coherent_avg_ram
  import coherent_avg_pkg::*;
#(
  parameter int WIDTH  = 96,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [WIDTH-1:0]  rd
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end

endmodule

// File: rtl/coherent_avg_mc.sv
// Multi-channel coherent averager: accumulates N frames of M points per channel,
// then streams one shifted/saturated frame out on an Avalon-ST source.
module coherent_avg_mc
  import coherent_avg_pkg::*;
#(
  parameter int N_CH   = 2,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 48,
  parameter int DEPTH  = 2048,
  parameter int ADDR_W = 11
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     mode_continuous,
  input  logic [15:0]              ptos_x_ciclo,
  input  logic [15:0]              frames_prom_coherente,
  input  logic [4:0]               shift_out,
  input  logic                     data_in_valid,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  input  logic                     data_out_ready,
  output logic                     data_out_valid,
  output logic [N_CH*DATA_W-1:0]   data_out,
  output logic                     data_out_sop,
  output logic                     data_out_eop,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun,
  output logic                     cfg_error
);

  state_t state_q, state_d;

  logic [15:0] m_q, n_q;
  logic [4:0]  sh_q;
  logic        cont_q;
  logic        cfg_ok;

  logic [15:0] idx, frm;
  logic        vld_p0, vld_p1, first_p1, last_p1;
  logic [ADDR_W-1:0]      idx_p1;
  logic [N_CH*DATA_W-1:0] sample_p1;

  logic [15:0] rd_idx, pend_idx;
  logic        pend_p1, issue, xfer, take_slot, flush;
  logic        out_ld_skid, out_ld_ram, skid_ld_ram;
  logic [1:0]  occ;
  logic        skid_vld, skid_sop, skid_eop;
  logic [N_CH*DATA_W-1:0] skid_data, sat_data;

  logic [N_CH*ACC_W-1:0]  ram_q, wr_data;
  logic [ADDR_W-1:0]      ram_ra;

  assign cfg_ok = (32'(ptos_x_ciclo) >= M_MIN) && (32'(ptos_x_ciclo) <= DEPTH) &&
                  (frames_prom_coherente != 16'd0);

  // Samples arriving after the final frame is complete are ignored.
  assign vld_p0 = (state_q == ST_ACCUM) && enable && data_in_valid && (frm != n_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable && cfg_ok) state_d = ST_ACCUM;
      ST_ACCUM: begin
        if (!enable)                state_d = ST_IDLE;
        else if (vld_p1 && last_p1) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (xfer && data_out_eop) begin
          if (!enable)     state_d = ST_IDLE;
          else if (cont_q) state_d = ST_ACCUM;
          else             state_d = ST_DONE;
        end else if (!enable) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE:  if (!enable) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
    done = (state_q == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q       <= '0;
      n_q       <= '0;
      sh_q      <= '0;
      cont_q    <= 1'b0;
      idx       <= '0;
      frm       <= '0;
      vld_p1    <= 1'b0;
      cfg_error <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        idx <= '0;
        frm <= '0;
        if (state_d == ST_ACCUM) begin
          m_q    <= ptos_x_ciclo;
          n_q    <= frames_prom_coherente;
          sh_q   <= shift_out;
          cont_q <= mode_continuous;
        end
      end else if (state_q == ST_DRAIN && state_d == ST_ACCUM) begin
        idx <= '0;
        frm <= '0;
      end else if (vld_p0) begin
        if (idx == m_q - 16'd1) begin
          idx <= '0;
          frm <= frm + 16'd1;
        end else begin
          idx <= idx + 16'd1;
        end
      end
      vld_p1 <= vld_p0;

      if (state_q == ST_IDLE) begin
        if (enable && !cfg_ok) cfg_error <= 1'b1;
        else if (cfg_ok)       cfg_error <= 1'b0;
      end

      if (state_q == ST_IDLE)                         overrun <= 1'b0;
      else if (state_q == ST_DRAIN && data_in_valid)  overrun <= 1'b1;
    end
  end

  // ---- p0 -> p1: sample captured while RAM[idx] is read ----
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      idx_p1    <= idx[ADDR_W-1:0];
      sample_p1 <= data_in;
      first_p1  <= (frm == 16'd0);
      last_p1   <= (frm == n_q - 16'd1) && (idx == m_q - 16'd1);
    end
    if (issue)       pend_idx  <= rd_idx;
    if (skid_ld_ram) skid_data <= sat_data;
  end

  // ---- p1: per-channel read-modify-write, and drain-side scaling of RAM output ----
  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic signed [DATA_W-1:0] smp;
    logic signed [ACC_W-1:0]  acc_rd;
    logic signed [ACC_W-1:0]  acc_wr;
    assign smp    = sample_p1[ch*DATA_W +: DATA_W];
    assign acc_rd = ram_q[ch*ACC_W +: ACC_W];
    assign acc_wr = first_p1 ? ACC_W'(smp) : acc_rd + ACC_W'(smp);
    assign wr_data[ch*ACC_W +: ACC_W]    = acc_wr;
    assign sat_data[ch*DATA_W +: DATA_W] = DATA_W'(shift_sat(64'(acc_rd), sh_q, DATA_W));
  end

  assign ram_ra = (state_q == ST_DRAIN) ? rd_idx[ADDR_W-1:0] : idx[ADDR_W-1:0];

  coherent_avg_ram #(
    .WIDTH  (N_CH*ACC_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk (clk),
    .we  (vld_p1),
    .wa  (idx_p1),
    .wd  (wr_data),
    .ra  (ram_ra),
    .rd  (ram_q)
  );

  // Reads are issued only while output register + skid + in-flight read stay within two beats.
  always_comb begin
    xfer        = data_out_valid && data_out_ready;
    flush       = (state_d != ST_DRAIN);
    occ         = {1'b0, data_out_valid} + {1'b0, skid_vld} + {1'b0, pend_p1};
    issue       = (state_q == ST_DRAIN) && !flush && (rd_idx < m_q) && ((occ < 2'd2) || xfer);
    take_slot   = !data_out_valid || xfer;
    out_ld_skid = take_slot && skid_vld;
    out_ld_ram  = take_slot && !skid_vld && pend_p1;
    skid_ld_ram = pend_p1 && !out_ld_ram;
  end

  // ---- p2: output register with one-deep skid ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_idx         <= '0;
      pend_p1        <= 1'b0;
      skid_vld       <= 1'b0;
      skid_sop       <= 1'b0;
      skid_eop       <= 1'b0;
      data_out_valid <= 1'b0;
      data_out_sop   <= 1'b0;
      data_out_eop   <= 1'b0;
      data_out       <= '0;
    end else begin
      if (state_q != ST_DRAIN) rd_idx <= '0;
      else if (issue)          rd_idx <= rd_idx + 16'd1;
      pend_p1 <= issue;

      if (flush) begin
        data_out_valid <= 1'b0;
        data_out_sop   <= 1'b0;
        data_out_eop   <= 1'b0;
        skid_vld       <= 1'b0;
      end else begin
        if (out_ld_skid) begin
          data_out     <= skid_data;
          data_out_sop <= skid_sop;
          data_out_eop <= skid_eop;
        end else if (out_ld_ram) begin
          data_out     <= sat_data;
          data_out_sop <= (pend_idx == 16'd0);
          data_out_eop <= (pend_idx == m_q - 16'd1);
        end
        if (take_slot) data_out_valid <= out_ld_skid || out_ld_ram;

        if (skid_ld_ram) begin
          skid_vld <= 1'b1;
          skid_sop <= (pend_idx == 16'd0);
          skid_eop <= (pend_idx == m_q - 16'd1);
        end else if (out_ld_skid) begin
          skid_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_coherent_avg_mc.sv
// Directed bench for coherent_avg_mc: averaging, scaling/saturation, backpressure,
// continuous mode, config errors, abort and asynchronous reset.
module tb_coherent_avg_mc;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        mode_continuous = 1'b0;
  logic [15:0] ptos_x_ciclo = '0;
  logic [15:0] frames_prom_coherente = '0;
  logic [4:0]  shift_out = '0;
  logic        data_in_valid = 1'b0;
  logic [63:0] data_in = '0;
  logic        data_out_ready = 1'b0;
  logic        data_out_valid;
  logic [63:0] data_out;
  logic        data_out_sop, data_out_eop, busy, done, overrun, cfg_error;

  int n_checks = 0;
  int n_errors = 0;
  logic signed [31:0] in0 [16];
  logic signed [31:0] in1 [16];

  always #5 clk = ~clk;

  coherent_avg_mc dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .enable                (enable),
    .mode_continuous       (mode_continuous),
    .ptos_x_ciclo          (ptos_x_ciclo),
    .frames_prom_coherente (frames_prom_coherente),
    .shift_out             (shift_out),
    .data_in_valid         (data_in_valid),
    .data_in               (data_in),
    .data_out_ready        (data_out_ready),
    .data_out_valid        (data_out_valid),
    .data_out              (data_out),
    .data_out_sop          (data_out_sop),
    .data_out_eop          (data_out_eop),
    .busy                  (busy),
    .done                  (done),
    .overrun               (overrun),
    .cfg_error             (cfg_error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected channel output when every frame carries the same sample x.
  function automatic logic [31:0] expv(input logic signed [31:0] x, input int nfr, input int sh);
    longint s;
    s = longint'(x) * longint'(nfr);
    s = s >>> sh;
    if (s > 64'sd2147483647)       s = 64'sd2147483647;
    else if (s < -64'sd2147483648) s = -64'sd2147483648;
    return 32'(s);
  endfunction

  task automatic cfg(input int m, input int n, input int sh, input bit cont);
    enable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ptos_x_ciclo          = 16'(m);
    frames_prom_coherente = 16'(n);
    shift_out             = 5'(sh);
    mode_continuous       = cont;
    enable                = 1'b1;
  endtask

  task automatic feed(input int m, input int nsamp);
    int t = 0;
    while (!busy && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("busy_wait", busy, 1);
    for (int k = 0; k < nsamp; k++) begin
      data_in_valid = 1'b1;
      data_in       = {in1[k % m], in0[k % m]};
      @(posedge clk); #1;
    end
    data_in_valid = 1'b0;
  endtask

  task automatic collect(input int m, input int nfr, input int sh, input bit bp,
                         input bit ovr_poke, output int lat);
    int          got = 0;
    int          cyc = 0;
    bit          hold = 1'b0;
    logic [63:0] prev = '0;
    logic [3:0]  pat = 4'b1001;
    logic        rdy;
    lat = 0;
    while (got < m && cyc < 200) begin
      if (hold) begin
        chk("hold_v", data_out_valid, 1);
        chk("hold_d", data_out, prev);
      end
      rdy = bp ? pat[cyc % 4] : 1'b1;
      data_out_ready = rdy;
      if (data_out_valid && ovr_poke) begin
        data_in_valid = 1'b1;
        ovr_poke      = 1'b0;
      end else begin
        data_in_valid = 1'b0;
      end
      if (!data_out_valid && got == 0) lat++;
      if (data_out_valid && rdy) begin
        chk($sformatf("b%0d_ch0", got), data_out[31:0],  expv(in0[got], nfr, sh));
        chk($sformatf("b%0d_ch1", got), data_out[63:32], expv(in1[got], nfr, sh));
        chk($sformatf("b%0d_sop", got), data_out_sop, got == 0);
        chk($sformatf("b%0d_eop", got), data_out_eop, got == m - 1);
        got++;
      end
      hold = data_out_valid && !rdy;
      prev = data_out;
      @(posedge clk); #1;
      cyc++;
    end
    data_in_valid = 1'b0;
    chk("beats", got, m);
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!data_out_valid && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    chk("wait_valid", data_out_valid, 1);
  endtask

  initial begin
    int lat;
    #12;
    chk("rst_valid", data_out_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_sop", data_out_sop, 0);
    chk("rst_eop", data_out_eop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_cfgerr", cfg_error, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Ramp, ch1 = -ch0, three frames, single shot
    for (int i = 0; i < 4; i++) begin
      in0[i] = 32'(i + 1);
      in1[i] = -32'(i + 1);
    end
    cfg(4, 3, 0, 1'b0);
    feed(4, 12);
    collect(4, 3, 0, 1'b0, 1'b0, lat);
    chk("latency", lat, 3);
    chk("done", done, 1);
    chk("busy_in_done", busy, 0);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("done_clr", done, 0);

    // Constant 100, N=4, shift 2 gives the true mean
    for (int i = 0; i < 8; i++) begin
      in0[i] = 32'sd100;
      in1[i] = 32'sd100;
    end
    cfg(8, 4, 2, 1'b0);
    feed(8, 32);
    collect(8, 4, 2, 1'b0, 1'b0, lat);

    // Positive and negative full-scale saturation
    for (int i = 0; i < 4; i++) begin
      in0[i] = 32'sh7FFFFFFF;
      in1[i] = 32'sh80000000;
    end
    cfg(4, 4, 0, 1'b0);
    feed(4, 16);
    collect(4, 4, 0, 1'b0, 1'b0, lat);

    // Backpressure with distinct data per point
    for (int i = 0; i < 8; i++) begin
      in0[i] = 32'(7 * i + 3);
      in1[i] = -32'(5 * i + 1);
    end
    cfg(8, 2, 1, 1'b0);
    feed(8, 16);
    collect(8, 2, 1, 1'b1, 1'b0, lat);

    // Continuous mode, three rounds; a sample poked during the first drain sets overrun
    cfg(4, 2, 0, 1'b1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) begin
        in0[i] = 32'(100 * (r + 1) + i);
        in1[i] = -32'(10 * r + i + 1);
      end
      feed(4, 8);
      collect(4, 2, 0, 1'b0, r == 0, lat);
      if (r == 0) chk("overrun_set", overrun, 1);
    end
    chk("cont_busy", busy, 1);
    chk("cont_done", done, 0);
    chk("overrun_sticky", overrun, 1);
    enable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("overrun_clr", overrun, 0);

    // Config errors, then a minimal valid frame
    cfg(1, 1, 0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("cfg_m1_err", cfg_error, 1);
    chk("cfg_m1_idle", busy, 0);
    ptos_x_ciclo = 16'd2049;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("cfg_big_err", cfg_error, 1);
    chk("cfg_big_idle", busy, 0);
    in0[0] = 32'sd1234;   in0[1] = -32'sd5;
    in1[0] = -32'sd99999; in1[1] = 32'sd42;
    ptos_x_ciclo = 16'd2;
    feed(2, 2);
    collect(2, 1, 0, 1'b0, 1'b0, lat);
    chk("cfg_err_clr", cfg_error, 0);

    // Abort mid-accumulation
    data_out_ready = 1'b0;
    cfg(8, 2, 0, 1'b0);
    feed(8, 5);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("abort_acc_busy", busy, 0);
    chk("abort_acc_valid", data_out_valid, 0);

    // Abort mid-drain while the sink stalls
    cfg(4, 1, 0, 1'b0);
    feed(4, 4);
    wait_valid();
    enable = 1'b0;
    @(posedge clk); #1;
    chk("abort_dr_valid", data_out_valid, 0);
    chk("abort_dr_eop", data_out_eop, 0);
    chk("abort_dr_busy", busy, 0);

    // Asynchronous reset with a beat pending
    cfg(4, 1, 0, 1'b0);
    feed(4, 4);
    wait_valid();
    chk("pre_rst_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", data_out_valid, 0);
    chk("arst_data", data_out, 0);
    chk("arst_sop", data_out_sop, 0);
    chk("arst_busy", busy, 0);
    enable = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
